// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the datapath blocks.
//   WIDTH  : default operand/result width
//   word_t : WIDTH-bit unsigned word
package arith_pkg;

  localparam int unsigned WIDTH = 20;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full adders.
//   x, y : addends
//   cin  : carry into bit 0
//   sum  : (x + y + cin) mod 2^WIDTH
//   cout : carry out of the MSB
module ripple_carry_adder #(
  parameter int unsigned WIDTH = arith_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/complement_subtractor.sv
// Registered two's-complement and subtract unit, one cycle of latency.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : a/b valid this cycle; outputs load only when set
//   a, b      : operands (a is also the complement operand)
//   comp_out  : (~a + 1) mod 2^WIDTH
//   diff      : (a - b) mod 2^WIDTH
//   cout      : carry out of a + ~b + 1 (1 = no borrow)
//   out_valid : registered in_valid
module complement_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] comp_out,
  output logic [WIDTH-1:0] diff,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] comp_sum;
  logic [WIDTH-1:0] diff_sum;
  logic             diff_carry;
  logic             comp_carry_unused;

  logic [WIDTH-1:0] comp_q, comp_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_comp_add (
    .x    (~a),
    .y    ('0),
    .cin  (1'b1),
    .sum  (comp_sum),
    .cout (comp_carry_unused)
  );

  ripple_carry_adder #(.WIDTH(WIDTH)) u_sub_add (
    .x    (a),
    .y    (~b),
    .cin  (1'b1),
    .sum  (diff_sum),
    .cout (diff_carry)
  );

  // Results load only on valid input, so an idle bus never reaches the outputs.
  always_comb begin
    comp_d  = comp_q;
    diff_d  = diff_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      comp_d = comp_sum;
      diff_d = diff_sum;
      cout_d = diff_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      comp_q  <= '0;
      diff_q  <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      comp_q  <= comp_d;
      diff_q  <= diff_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign comp_out  = comp_q;
  assign diff      = diff_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_complement_subtractor.sv
// Directed self-checking bench for complement_subtractor (WIDTH = 20).
module tb_complement_subtractor;

  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] comp_out;
  logic [W-1:0] diff;
  logic         cout;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  complement_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .comp_out  (comp_out),
    .diff      (diff),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] ec, input logic [W-1:0] ed,
                            input logic eco, input logic ev);
    check_eq({tag, ".comp"},  32'(comp_out),  32'(ec));
    check_eq({tag, ".diff"},  32'(diff),      32'(ed));
    check_eq({tag, ".cout"},  32'(cout),      32'(eco));
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(ev));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] comp;
    logic [W-1:0] diff;
    logic         cout;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 20'h12345;
    b        = 20'h54321;

    // Reset held for two cycles with valid operands present.
    cycle(1'b1, 1'b1, 20'h12345, 20'h54321);
    expect_out("rst0", 20'h0, 20'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 20'hABCDE, 20'h00007);
    expect_out("rst1", 20'h0, 20'h0, 1'b0, 1'b0);

    // Complement sweep (b = 0), then subtraction cases, all back-to-back.
    vecs.push_back('{20'h00000, 20'h00000, 20'h00000, 20'h00000, 1'b1});
    vecs.push_back('{20'h7FFFF, 20'h00000, 20'h80001, 20'h7FFFF, 1'b1});
    vecs.push_back('{20'hFFFFF, 20'h00000, 20'h00001, 20'hFFFFF, 1'b1});
    vecs.push_back('{20'h55555, 20'h00000, 20'hAAAAB, 20'h55555, 1'b1});
    vecs.push_back('{20'h80000, 20'h00000, 20'h80000, 20'h80000, 1'b1});
    vecs.push_back('{20'h00001, 20'h00000, 20'hFFFFF, 20'h00001, 1'b1});
    vecs.push_back('{20'hFFFFF, 20'h00001, 20'h00001, 20'hFFFFE, 1'b1});
    vecs.push_back('{20'hAAAAA, 20'h55555, 20'h55556, 20'h55555, 1'b1});
    vecs.push_back('{20'h00000, 20'h7FFFF, 20'h00000, 20'h80001, 1'b0});
    vecs.push_back('{20'h00003, 20'h00005, 20'hFFFFD, 20'hFFFFE, 1'b0});
    vecs.push_back('{20'hFFFFF, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1});

    foreach (vecs[i]) begin
      cycle(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      expect_out($sformatf("vec%0d", i), vecs[i].comp, vecs[i].diff, vecs[i].cout, 1'b1);
    end

    // Idle bus with changing operands: last result must hold.
    cycle(1'b0, 1'b0, 20'h12345, 20'h00001);
    expect_out("hold0", 20'h00001, 20'h00000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 20'h00000, 20'hFFFFF);
    expect_out("hold1", 20'h00001, 20'h00000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 20'h0F0F0, 20'hF0F0F);
    expect_out("hold2", 20'h00001, 20'h00000, 1'b1, 1'b0);

    // Reset coinciding with a valid pair discards that pair.
    cycle(1'b1, 1'b1, 20'h00001, 20'h00002);
    expect_out("midrst", 20'h0, 20'h0, 1'b0, 1'b0);

    // Operation resumes one cycle after reset drops.
    cycle(1'b0, 1'b1, 20'h00010, 20'h00001);
    expect_out("resume", 20'hFFFF0, 20'h0000F, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complement_subtractor.md
Name: complement_subtractor

Overview:
- Registered 20-bit two's-complement unit and 20-bit subtractor in one arithmetic block.
- Produces -a (two's complement of operand a) and a - b with carry-out, for use by the arithmetic datapath.
- Combinational core is a ripple-carry adder. Results are registered once on clk.

Parameters:
- WIDTH, 20, operand/result bit width (all requirements below are stated for 20; must hold for any WIDTH >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  WIDTH  minuend; also the operand for complement
- b  input  WIDTH  subtrahend
- comp_out  output  WIDTH  registered two's complement of a: (~a + 1) mod 2^WIDTH
- diff  output  WIDTH  registered (a - b) mod 2^WIDTH
- cout  output  1  registered carry-out of a + ~b + 1 (1 = no borrow, i.e. a >= b unsigned)
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: comp_out=0, diff=0, cout=0, out_valid=0.
  - rst overrides in_valid. Reset mid-stream discards any in-flight result.
- Latency:
  - Exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
  - Full throughput: a new operand pair is accepted every cycle, with no stall or backpressure.
- Hold:
  - When in_valid=0 (and rst=0), comp_out/diff/cout hold their previous values.
  - out_valid goes 0 in that case.
- Complement:
  - comp_out = bitwise invert of a, plus 1, truncated to WIDTH.
  - comp(0) = 0. comp(0x80000) = 0x80000 (most-negative value maps to itself; no flag).
- Subtraction:
  - diff = a + (~b) + 1 computed as one WIDTH-bit ripple add with carry-in 1.
  - cout = carry out of the MSB of that add.
  - b=0 gives diff=a, cout=1. a<b unsigned gives cout=0 and wrap-around result.
  - No signed overflow output; signed interpretation is left to the consumer.
- Purely unsigned modular arithmetic. No saturation.
- No X propagation into outputs from an idle bus: outputs only load when in_valid=1.

Decomposition:
- Shared package arith_pkg: constant WIDTH default (20) and a typedef for a WIDTH-bit word. Other arithmetic blocks reuse it.
- One sub-module, ripple_carry_adder (WIDTH-bit, inputs x, y, cin; outputs sum, cout), built from a per-bit full-adder generate loop.
  - Instance 1 (complement): x=~a, y=0, cin=1.
  - Instance 2 (subtraction): x=a, y=~b, cin=1.
- Top-level holds only the inversions, the output registers and reset/valid logic.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and arbitrary a/b -> comp_out=0, diff=0, cout=0, out_valid=0. Deassert rst -> first valid result appears 1 cycle later.
- Complement sweep, one per cycle with in_valid=1: a=0x00000 -> comp_out=0x00000; a=0x7FFFF -> 0x80001; a=0xFFFFF -> 0x00001; a=0x55555 -> 0xAAAAB.
- Subtraction with no borrow:
  - a=0x00001, b=0x00000 -> diff=0x00001, cout=1.
  - a=0xFFFFF, b=0x00001 -> diff=0xFFFFE, cout=1.
  - a=0xAAAAA, b=0x55555 -> diff=0x55555, cout=1.
- Subtraction with borrow/equal:
  - a=0x00000, b=0x7FFFF -> diff=0x80001, cout=0.
  - a=0xFFFFF, b=0xFFFFF -> diff=0x00000, cout=1.
- Hold/valid: apply a valid pair, then in_valid=0 with changing a/b for 3 cycles -> outputs hold the last result, out_valid=0. Back-to-back valid pairs -> results stream with 1-cycle latency and out_valid=1 every cycle.
- Reset mid-operation: rst=1 in the same cycle as a valid pair -> outputs are 0 next cycle, not the result of that pair.
